// File: rtl/pll_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor and its per-channel FSMs.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_sup_state_t;

  localparam int LOSS_CNT_W = 8;

  // Used to size the shared phase counter from the longest interval it must time.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_channel.sv
// One supervised PLL: lock synchronizer, reset/lock/stability FSM with retry and fault handling.
// Lock-loss statistics are built only when PLL_LOCK_STATS_EN is defined.
module pll_lock_channel
  import pll_supervisor_pkg::*;
#(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 125000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lock_async,
  input  logic                  clear_fault,
  output logic                  pll_rst,
  output logic                  domain_rst_n,
  output logic                  fault,
  output logic                  in_run,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int CNT_W = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_PULSE) + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST     = RTY_W'(MAX_RETRIES - 1);

  logic [1:0]     sync_q;
  logic           lock_s;
  pll_sup_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retries_q, retries_d;
  logic           pll_rst_q, pll_rst_d;
  logic           domain_rst_n_q, domain_rst_n_d;
  logic           fault_q, fault_d;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    retries_d = retries_q;
    case (state_q)
      RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d     = '0;
          retries_d = retries_q + RTY_W'(1);
          state_d   = (retries_q == RTY_LAST) ? FAULT : RESET;
        end
      end
      STABLE: begin
        // Lock loss is checked first so a glitch on the terminal count still restarts.
        if (!lock_s) begin
          state_d = RESET;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          retries_d = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = RESET;
      end
      FAULT: begin
        cnt_d = '0;
        if (clear_fault) begin
          state_d   = RESET;
          retries_d = '0;
        end
      end
      default: begin
        state_d = RESET;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    pll_rst_d      = (state_d == RESET) || (state_d == FAULT);
    domain_rst_n_d = (state_d == RUN);
    fault_d        = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q         <= '0;
      state_q        <= RESET;
      cnt_q          <= '0;
      retries_q      <= '0;
      pll_rst_q      <= 1'b1;
      domain_rst_n_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      sync_q         <= {sync_q[0], lock_async};
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retries_q      <= retries_d;
      pll_rst_q      <= pll_rst_d;
      domain_rst_n_q <= domain_rst_n_d;
      fault_q        <= fault_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst_n = domain_rst_n_q;
  assign fault        = fault_q;
  assign in_run       = (state_q == RUN);

`ifdef PLL_LOCK_STATS_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  lock_lost;

  assign lock_lost = (state_q == RUN) && !lock_s;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_cnt_q <= '0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign lock_loss_count = loss_cnt_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises NUM_PLLS MMCM/PLLs: reset pulsing, lock wait with retry, stability qualification, domain resets.
// Define PLL_LOCK_STATS_EN to build the per-channel saturating lock-loss counters.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int NUM_PLLS      = 2,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 125000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PLLS-1:0]            lock_async,
  input  logic [NUM_PLLS-1:0]            clear_fault,
  output logic [NUM_PLLS-1:0]            pll_rst,
  output logic [NUM_PLLS-1:0]            domain_rst_n,
  output logic                           all_locked,
  output logic [NUM_PLLS-1:0]            fault,
  output logic [LOSS_CNT_W*NUM_PLLS-1:0] lock_loss_count
);

  logic [NUM_PLLS-1:0] in_run;
  logic                all_locked_q, all_locked_d;

  for (genvar gi = 0; gi < NUM_PLLS; gi++) begin : g_ch
    pll_lock_channel #(
      .RST_PULSE    (RST_PULSE),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .lock_async     (lock_async[gi]),
      .clear_fault    (clear_fault[gi]),
      .pll_rst        (pll_rst[gi]),
      .domain_rst_n   (domain_rst_n[gi]),
      .fault          (fault[gi]),
      .in_run         (in_run[gi]),
      .lock_loss_count(lock_loss_count[gi*LOSS_CNT_W +: LOSS_CNT_W])
    );
  end

  always_comb all_locked_d = &in_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_locked_q <= 1'b0;
    else        all_locked_q <= all_locked_d;
  end

  assign all_locked = all_locked_q;

endmodule
